// File: rtl/post_neuron_updater.sv
// Read-modify-write controller for the post-neuron state SRAM: integrate-and-fire events plus leak sweep.
// Build option POST_RESET_SUB_EN: on fire, Vmem = sum - threshold (saturated) instead of 0.
module post_neuron_updater #(
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned SRAM_DEPTH   = 256,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned LEAK_SHIFT   = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDR_WIDTH-1:0]   in_addr,
    input  logic [WEIGHT_WIDTH-1:0] in_weight,
    input  logic [15:0]             threshold,
    input  logic                    sweep_start,
    output logic                    sweep_busy,
    output logic                    sweep_done,
    output logic                    spike_valid,
    output logic [ADDR_WIDTH-1:0]   spike_addr,
    output logic                    SRAM_CS,
    output logic                    SRAM_WE,
    output logic [ADDR_WIDTH-1:0]   SRAM_A,
    output logic [DATA_WIDTH-1:0]   SRAM_D,
    input  logic [DATA_WIDTH-1:0]   SRAM_Q
);

    typedef enum logic [1:0] {StIdle, StRead, StCalc, StWrite} state_e;

    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(SRAM_DEPTH - 1);

    state_e                         state_q, state_d;
    logic [ADDR_WIDTH-1:0]          addr_q, addr_d;
    logic signed [WEIGHT_WIDTH-1:0] weight_q, weight_d;
    logic                           sweep_q, sweep_d;
    logic                           in_ready_q, in_ready_d;

    logic                           cs_d, we_d;
    logic [ADDR_WIDTH-1:0]          a_d;
    logic [DATA_WIDTH-1:0]          d_d;
    logic                           spike_valid_d, sweep_done_d;
    logic [ADDR_WIDTH-1:0]          spike_addr_d;

    logic                           accept;
    logic                           fire;
    logic [DATA_WIDTH-1:0]          new_word;

    logic signed [15:0]             vmem, thr_s, vmem_sat, vmem_new;
    logic signed [16:0]             sum;
    logic [11:0]                    cnt, cnt_new;
`ifdef POST_RESET_SUB_EN
    logic signed [17:0]             diff;
`endif

    // A same-cycle sweep_start masks the ready flag so the event is held off.
    assign in_ready   = in_ready_q & ~sweep_start;
    assign sweep_busy = sweep_q;
    assign accept     = in_valid & in_ready;

    // Datapath: only meaningful in CALC, when SRAM_Q holds the word read in READ.
    always_comb begin
        vmem  = SRAM_Q[15:0];
        cnt   = SRAM_Q[27:16];
        thr_s = threshold;
        sum   = 17'(vmem) + 17'(weight_q);
        if (sum[16] != sum[15]) begin
            vmem_sat = sum[16] ? 16'sh8000 : 16'sh7fff;
        end else begin
            vmem_sat = sum[15:0];
        end
        fire     = !sweep_q && (vmem_sat >= thr_s);
        cnt_new  = cnt;
        vmem_new = vmem_sat;
`ifdef POST_RESET_SUB_EN
        diff     = 18'(vmem_sat) - 18'(thr_s);
`endif
        if (sweep_q) begin
            vmem_new = vmem - (vmem >>> LEAK_SHIFT);
        end else if (fire) begin
            cnt_new = cnt + 12'd1;
`ifdef POST_RESET_SUB_EN
            // diff is non-negative when firing; only the positive rail can be exceeded.
            if (diff[17:15] != 3'b000) begin
                vmem_new = 16'sh7fff;
            end else begin
                vmem_new = diff[15:0];
            end
`else
            vmem_new = '0;
`endif
        end
        new_word = {SRAM_Q[31:28], cnt_new, vmem_new};
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        weight_d = weight_q;
        sweep_d  = sweep_q;
        unique case (state_q)
            StIdle: begin
                if (sweep_start) begin
                    state_d = StRead;
                    addr_d  = '0;
                    sweep_d = 1'b1;
                end else if (accept) begin
                    state_d  = StRead;
                    addr_d   = in_addr;
                    weight_d = in_weight;
                    sweep_d  = 1'b0;
                end
            end
            StRead:  state_d = StCalc;
            StCalc:  state_d = StWrite;
            StWrite: begin
                if (sweep_q && (addr_q != LastAddr)) begin
                    state_d = StRead;
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                end else begin
                    state_d = StIdle;
                    sweep_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered, so their next values follow the next state.
    always_comb begin
        in_ready_d    = (state_d == StIdle);
        cs_d          = (state_d == StRead) || (state_d == StWrite);
        we_d          = (state_d == StWrite);
        a_d           = addr_d;
        d_d           = (state_d == StWrite) ? new_word : '0;
        spike_valid_d = (state_d == StWrite) && fire;
        spike_addr_d  = spike_valid_d ? addr_q : spike_addr;
        sweep_done_d  = (state_d == StWrite) && sweep_q && (addr_q == LastAddr);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            weight_q    <= '0;
            sweep_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            SRAM_CS     <= 1'b0;
            SRAM_WE     <= 1'b0;
            SRAM_A      <= '0;
            SRAM_D      <= '0;
            spike_valid <= 1'b0;
            spike_addr  <= '0;
            sweep_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            weight_q    <= weight_d;
            sweep_q     <= sweep_d;
            in_ready_q  <= in_ready_d;
            SRAM_CS     <= cs_d;
            SRAM_WE     <= we_d;
            SRAM_A      <= a_d;
            SRAM_D      <= d_d;
            spike_valid <= spike_valid_d;
            spike_addr  <= spike_addr_d;
            sweep_done  <= sweep_done_d;
        end
    end

endmodule

// File: tb/tb_post_neuron_updater.sv
// Bench for post_neuron_updater: vector table, hand sequences (sweep, hazards, reset) and
// randomized events against an integer reference model of the state word.
module tb_post_neuron_updater;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 256;
    localparam int WW    = 8;
    localparam int LS    = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          in_valid, in_ready;
    logic [AW-1:0] in_addr;
    logic [WW-1:0] in_weight;
    logic [15:0]   threshold;
    logic          sweep_start, sweep_busy, sweep_done;
    logic          spike_valid;
    logic [AW-1:0] spike_addr;
    logic          SRAM_CS, SRAM_WE;
    logic [AW-1:0] SRAM_A;
    logic [DW-1:0] SRAM_D, SRAM_Q;

    always #5 CLK = ~CLK;

    post_neuron_updater #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SRAM_DEPTH(DEPTH), .WEIGHT_WIDTH(WW), .LEAK_SHIFT(LS)
    ) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_weight(in_weight), .threshold(threshold), .sweep_start(sweep_start),
        .sweep_busy(sweep_busy), .sweep_done(sweep_done), .spike_valid(spike_valid),
        .spike_addr(spike_addr), .SRAM_CS(SRAM_CS), .SRAM_WE(SRAM_WE), .SRAM_A(SRAM_A),
        .SRAM_D(SRAM_D), .SRAM_Q(SRAM_Q)
    );

    // SRAM model with registered read data; preload port used only while the DUT is idle.
    logic [31:0] mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] q_reg;
    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [31:0] pl_data;
    assign SRAM_Q = q_reg;

    always @(posedge CLK) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (SRAM_CS && SRAM_WE) mem[SRAM_A] <= SRAM_D;
        if (SRAM_CS && !SRAM_WE) q_reg <= mem[SRAM_A];
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int last_t0 = 0;

    typedef struct {
        logic [7:0]  addr;
        int          wt;
        int          thr;
        logic [31:0] init;
        logic [31:0] exp_w;
        logic [31:0] exp_w_sub;
        bit          spike;
    } vec_t;
    vec_t vecs [8];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_idle(input string nm);
        check(nm, {in_ready, sweep_busy, sweep_done, spike_valid, spike_addr, SRAM_CS, SRAM_WE,
                   SRAM_A, SRAM_D}, 64'(1) << 53);
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        ref_mem[a] = d;
        step();
        pl_en = 1'b0;
    endtask

    function automatic int clamp16(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic logic [31:0] leak_model(input logic [31:0] w);
        int v, l;
        v = $signed(w[15:0]);
        l = (v >= 0) ? v / (1 << LS) : -((-v + (1 << LS) - 1) / (1 << LS));
        v = v - l;
        return {w[31:16], 16'(v)};
    endfunction

    task automatic ev_model(input logic [31:0] w, input int wt, input int thr,
                            output logic [31:0] nw, output bit fire);
        int v, s;
        logic [11:0] c;
        v = $signed(w[15:0]);
        s = clamp16(v + wt);
        c = w[27:16];
        fire = (s >= thr);
        if (fire) begin
            c = c + 12'd1;
`ifdef POST_RESET_SUB_EN
            s = clamp16(s - thr);
`else
            s = 0;
`endif
        end
        nw = {w[31:28], c, 16'(s)};
    endtask

    task automatic run_event(input logic [7:0] a, input int wt, input int thr,
                             input logic [31:0] exp_w, input bit exp_sp, input string tag);
        int n;
        logic [2:0] we_p, sp_p, rdy_p;
        logic [7:0] sa;
        n = 0;
        sa = 8'h00;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        check({tag, "_ready_in"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_addr = a; in_weight = 8'(wt); threshold = 16'(thr);
        last_t0 = cyc;
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            we_p[k-1]  = SRAM_WE;
            sp_p[k-1]  = spike_valid;
            rdy_p[k-1] = in_ready;
            if (spike_valid) sa = spike_addr;
            step();
        end
        check({tag, "_we_cycle3"}, 64'(we_p), 64'(3'b100));
        check({tag, "_spike"}, 64'(sp_p), 64'({exp_sp, 2'b00}));
        check({tag, "_ready_low"}, 64'(rdy_p), 64'd0);
        check({tag, "_ready_cycle4"}, 64'(in_ready), 64'd1);
        if (exp_sp) check({tag, "_spike_addr"}, 64'(sa), 64'(a));
        check({tag, "_word"}, 64'(mem[a]), 64'(exp_w));
        ref_mem[a] = exp_w;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0]  ra, rb;
        logic [31:0] nw, ew;
        bit          f;
        int          wt, thr, t_first, done_cnt, done_cyc, busy_err, rdy_err, spk_cnt, mm;

        RST = 1'b1; in_valid = 1'b0; in_addr = '0; in_weight = '0; threshold = '0;
        sweep_start = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;

        vecs[0] = '{8'h05,   20,    200, 32'h0003_0064, 32'h0003_0078, 32'h0003_0078, 1'b0};
        vecs[1] = '{8'h05,   15,    200, 32'h0003_00BE, 32'h0004_0000, 32'h0004_0005, 1'b1};
        vecs[2] = '{8'h10,  127,  32767, 32'hA000_7FF8, 32'hA001_0000, 32'hA001_0000, 1'b1};
        vecs[3] = '{8'h11, -128,    200, 32'h0005_8008, 32'h0005_8000, 32'h0005_8000, 1'b0};
        vecs[4] = '{8'h12,    1,      1, 32'h5FFF_0000, 32'h5000_0000, 32'h5000_0000, 1'b1};
        vecs[5] = '{8'h13,   -1,   -200, 32'h0000_FF9C, 32'h0001_0000, 32'h0001_0063, 1'b1};
        vecs[6] = '{8'h14,  127, -32768, 32'h0002_7000, 32'h0003_0000, 32'h0003_7FFF, 1'b1};
        vecs[7] = '{8'h15,    1,    101, 32'h0000_0063, 32'h0000_0064, 32'h0000_0064, 1'b0};

        step();
        chk_idle("reset_outputs");
        for (int i = 0; i < DEPTH; i++) preload(8'(i), $urandom);
        RST = 1'b0;
        step();
        chk_idle("idle_after_reset");

        for (int i = 0; i < 8; i++) begin
`ifdef POST_RESET_SUB_EN
            ew = vecs[i].exp_w_sub;
`else
            ew = vecs[i].exp_w;
`endif
            preload(vecs[i].addr, vecs[i].init);
            run_event(vecs[i].addr, vecs[i].wt, vecs[i].thr, ew, vecs[i].spike,
                      $sformatf("vec%0d", i));
        end

        // Back-to-back events to one address must see each other's write.
        preload(8'h09, 32'h0000_0000);
        run_event(8'h09, 10, 1000, 32'h0000_000A, 1'b0, "b2b1");
        t_first = last_t0;
        run_event(8'h09, 10, 1000, 32'h0000_0014, 1'b0, "b2b2");
        check("b2b_gap", 64'(last_t0 - t_first), 64'd4);

        // Leak sweep with a colliding event in the start cycle.
        preload(8'd3, 32'h0007_00A0);
        preload(8'd200, 32'h0000_FFF0);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = leak_model(ref_mem[i]);
        sweep_start = 1'b1; in_valid = 1'b1; in_addr = 8'h40; in_weight = 8'h7F;
        #1;
        check("sweep_holds_ready", 64'(in_ready), 64'd0);
        step();
        sweep_start = 1'b0; in_valid = 1'b0;
        done_cnt = 0; done_cyc = 0; busy_err = 0; rdy_err = 0; spk_cnt = 0;
        for (int k = 1; k <= 3 * DEPTH + 1; k++) begin
            if (sweep_done) begin
                done_cnt++;
                done_cyc = k;
            end
            if (spike_valid) spk_cnt++;
            if (sweep_busy !== (k <= 3 * DEPTH)) busy_err++;
            if (in_ready !== (k == 3 * DEPTH + 1)) rdy_err++;
            if (k <= 3 * DEPTH) step();
        end
        check("sweep_done_count", 64'(done_cnt), 64'd1);
        check("sweep_done_cycle", 64'(done_cyc), 64'(3 * DEPTH));
        check("sweep_busy_window", 64'(busy_err), 64'd0);
        check("sweep_ready_window", 64'(rdy_err), 64'd0);
        check("sweep_no_spikes", 64'(spk_cnt), 64'd0);
        check("sweep_vmem160", 64'(mem[3]), 64'h0007_0096);
        check("sweep_vmem_m16", 64'(mem[200]), 64'h0000_FFF1);
        mm = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) mm++;
        check("sweep_all_words", 64'(mm), 64'd0);
        run_event(8'h40, 1, 30000, {ref_mem[8'h40][31:16], 16'(clamp16(
                  int'($signed(ref_mem[8'h40][15:0])) + 1))},
                  (clamp16(int'($signed(ref_mem[8'h40][15:0])) + 1) >= 30000) ? 1'b0 : 1'b0,
                  "post_sweep");

        // Reset while the event is in CALC: the write must be abandoned.
        preload(8'h22, 32'h0001_0100);
        in_valid = 1'b1; in_addr = 8'h22; in_weight = 8'd50; threshold = 16'd10000;
        step();
        in_valid = 1'b0;
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk_idle("reset_in_calc_outputs");
        step(); step(); step();
        check("reset_in_calc_word", 64'(mem[8'h22]), 64'h0001_0100);
        run_event(8'h22, 50, 10000, 32'h0001_0132, 1'b0, "after_reset");

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom_range(0, 7));
            rb = 8'($urandom);
            wt = int'($signed(rb));
            thr = (i % 4 == 0) ? int'($urandom_range(0, 65535)) - 32768
                               : int'($urandom_range(0, 600)) - 300;
            ev_model(ref_mem[ra], wt, thr, nw, f);
            run_event(ra, wt, thr, nw, f, "rand");
        end

        mm = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) mm++;
        check("final_all_words", 64'(mm), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
